// File: rtl/turn_request_gen.sv
// Turn-request generator: accepts the current player's flip button, issues a
// card-flip request, waits for the compare result, holds a mismatched card on
// display, then strobes next_turn. A win freezes everything until reset.
module turn_request_gen #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int RESULT_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] N,
  input  logic [1:0] T,
  input  logic [3:0] btn,
  input  logic       match_valid,
  input  logic       match,
  input  logic       win,
  output logic       flip_req,
  output logic [1:0] flip_player,
  output logic       next_turn,
  output logic       err_turn,
  output logic       busy
);

  localparam int MAX_CNT = (HOLD_CYCLES > RESULT_TIMEOUT) ? HOLD_CYCLES : RESULT_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RES_LOAD  = CW'(RESULT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RESULT,
    S_HOLD,
    S_ADVANCE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    btn_q;
  logic          armed;
  logic [3:0]    rise;
  logic          t_valid;
  logic          take;
  logic [3:0]    take_mask;
  logic          stray;

  // Button history. btn_q clears on reset; armed stays low for the first edge
  // after reset so a button held across reset release cannot look like a
  // fresh press (btn_q picks up the held level on that edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
    end
  end

  // Press decode: rising edges, current-player validity and stray presses.
  always_comb begin
    rise    = armed ? (btn & ~btn_q) : '0;
    t_valid = 1'b0;
    case (N)
      2'b00:   t_valid = (T < 2'd2);
      2'b01:   t_valid = (T < 2'd3);
      default: t_valid = 1'b1;
    endcase
    take      = rise[T] & t_valid;
    take_mask = take ? (4'b0001 << T) : '0;
    stray     = |(rise & ~take_mask);
  end

  // Turn sequencing FSM with registered strobes and a shared saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      flip_req    <= 1'b0;
      flip_player <= 2'b00;
      next_turn   <= 1'b0;
      err_turn    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      flip_req  <= 1'b0;
      next_turn <= 1'b0;
      err_turn  <= 1'b0;
      if (win) begin
        // Win overrides every transition, including a pending ADVANCE.
        state <= S_DONE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            err_turn <= stray;
            if (take) begin
              flip_req    <= 1'b1;
              flip_player <= T;
              cnt         <= RES_LOAD;
              state       <= S_WAIT_RESULT;
              busy        <= 1'b1;
            end
          end
          S_WAIT_RESULT: begin
            if (match_valid) begin
              if (match) begin
                state <= S_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
              end else begin
                state <= S_HOLD;
                cnt   <= HOLD_LOAD;
              end
            end else if (cnt == '0) begin
              // No result in time: treated as a mismatch.
              state <= S_HOLD;
              cnt   <= HOLD_LOAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_HOLD: begin
            if (cnt == '0) begin
              state <= S_ADVANCE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_ADVANCE: begin
            next_turn <= 1'b1;
            state     <= S_SETTLE;
          end
          S_SETTLE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_DONE: begin
            busy <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_request_gen.sv
// Bench for turn_request_gen: directed steps, strobe events scoreboarded by cycle.
module tb_turn_request_gen;

  localparam int HOLD = 4;
  localparam int RTO  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] N;
  logic [1:0] T;
  logic [3:0] btn;
  logic       match_valid;
  logic       match;
  logic       win;
  logic       flip_req;
  logic [1:0] flip_player;
  logic       next_turn;
  logic       err_turn;
  logic       busy;

  turn_request_gen #(
    .HOLD_CYCLES   (HOLD),
    .RESULT_TIMEOUT(RTO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .N          (N),
    .T          (T),
    .btn        (btn),
    .match_valid(match_valid),
    .match      (match),
    .win        (win),
    .flip_req   (flip_req),
    .flip_player(flip_player),
    .next_turn  (next_turn),
    .err_turn   (err_turn),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       fr;
    logic [1:0] fp;
    logic       nt;
    logic       et;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Queue a strobe event expected dly cycles after the current sample point.
  task automatic expect_ev(input int dly, input logic fr, input logic [1:0] fp,
                           input logic nt, input logic et);
    ev_t e;
    e.cyc = cyc + dly;
    e.fr  = fr;
    e.fp  = fp;
    e.nt  = nt;
    e.et  = et;
    q.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, score strobes.
  task automatic tick;
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check("missing_event_cycle", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (flip_req || next_turn || err_turn) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check("ev_flip_req", flip_req, e.fr);
        if (e.fr) check("ev_flip_player", flip_player, e.fp);
        check("ev_next_turn", next_turn, e.nt);
        check("ev_err_turn", err_turn, e.et);
      end else begin
        check("unexpected_strobe", {flip_req, next_turn, err_turn}, 3'b000);
      end
    end
  endtask

  initial begin
    rst = 1'b0; N = 2'b00; T = 2'd0; btn = '0;
    match_valid = 1'b0; match = 1'b0; win = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_flip_req", flip_req, 1'b0);
    check("rst_flip_player", flip_player, 2'b00);
    check("rst_next_turn", next_turn, 1'b0);
    check("rst_err_turn", err_turn, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick; tick;
    rst = 1'b0;
    tick;

    // Mismatch path: flip, HOLD, next_turn 5 cycles after HOLD entry.
    btn = 4'b0001;
    expect_ev(1, 1'b1, 2'd0, 1'b0, 1'b0);
    expect_ev(7, 1'b0, 2'd0, 1'b1, 1'b0);
    tick;
    check("s1_busy_wait", busy, 1'b1);
    btn = '0; match_valid = 1'b1; match = 1'b0;
    tick;
    match_valid = 1'b0; btn = 4'b0010;   // wrong-player press during HOLD: no err
    tick;
    btn = '0;
    tick; tick; tick;
    check("s1_busy_advance", busy, 1'b1);
    tick;
    tick;
    check("s1_busy_idle", busy, 1'b0);

    // Match path, N=3 players, T=2: turn kept, second press accepted.
    N = 2'b01; T = 2'd2;
    btn = 4'b0100;
    expect_ev(1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick;
    btn = '0; match_valid = 1'b1; match = 1'b1;
    tick;
    match_valid = 1'b0; match = 1'b0;
    check("s2_busy_after_match", busy, 1'b0);
    btn = 4'b0100;
    expect_ev(1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick;
    check("s2_busy_second", busy, 1'b1);
    btn = '0; match_valid = 1'b1; match = 1'b1;
    tick;
    match_valid = 1'b0; match = 1'b0;
    check("s2_busy_idle", busy, 1'b0);

    // Win during HOLD: DONE, no next_turn, presses ignored.
    btn = 4'b0100;
    expect_ev(1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick;
    btn = '0; match_valid = 1'b1; match = 1'b0;
    tick;
    match_valid = 1'b0;
    tick;
    win = 1'b1;
    tick;
    win = 1'b0;
    check("s5_busy_done", busy, 1'b0);
    btn = 4'b0100; tick;
    btn = '0; tick;
    btn = 4'b0110; tick;
    tick;
    check("s5_busy_done_late", busy, 1'b0);
    btn = '0;
    rst = 1'b1;
    #2;
    check("s5_rst_flip_player", flip_player, 2'b00);
    check("s5_rst_busy", busy, 1'b0);
    tick;
    rst = 1'b0;
    tick;
    btn = 4'b0100;
    expect_ev(1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick;
    btn = '0; match_valid = 1'b1; match = 1'b1;
    tick;
    match_valid = 1'b0; match = 1'b0;

    // Out-of-turn and invalid-player presses, then combined press.
    N = 2'b00; T = 2'd0;
    btn = 4'b0010;
    expect_ev(1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick;
    btn = '0; tick;
    btn = 4'b1000;
    expect_ev(1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick;
    btn = '0; tick;
    T = 2'd2; btn = 4'b0100;              // T=2 is not a player when N=00
    expect_ev(1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick;
    check("s3_busy_invalid", busy, 1'b0);
    btn = '0; T = 2'd0; tick;
    btn = 4'b0011;
    expect_ev(1, 1'b1, 2'd0, 1'b0, 1'b1);
    tick;
    btn = '0; match_valid = 1'b1; match = 1'b1;
    tick;
    match_valid = 1'b0; match = 1'b0;
    check("s3_busy_idle", busy, 1'b0);

    // Result timeout: HOLD after 8 cycles, next_turn 5 later.
    btn = 4'b0001;
    expect_ev(1, 1'b1, 2'd0, 1'b0, 1'b0);
    expect_ev(14, 1'b0, 2'd0, 1'b1, 1'b0);
    tick;
    btn = '0;
    repeat (6) tick;
    check("s4_busy_waiting", busy, 1'b1);
    repeat (10) tick;
    check("s4_busy_idle", busy, 1'b0);

    // Reset with HOLD counter at 1, button held across reset release.
    btn = 4'b0001;
    expect_ev(1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick;
    match_valid = 1'b1; match = 1'b0;
    tick;
    match_valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    #2;
    check("s6_rst_flip_req", flip_req, 1'b0);
    check("s6_rst_next_turn", next_turn, 1'b0);
    check("s6_rst_err_turn", err_turn, 1'b0);
    check("s6_rst_busy", busy, 1'b0);
    tick; tick;
    rst = 1'b0;
    repeat (5) tick;
    check("s6_busy_held_btn", busy, 1'b0);
    btn = '0; tick;
    btn = 4'b0001;
    expect_ev(1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick;
    btn = '0; match_valid = 1'b1; match = 1'b1;
    tick;
    match_valid = 1'b0; match = 1'b0;
    repeat (3) tick;
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
